sha_folded_double_core: RTL and testbench
=========================================

# sha_folded_double_core

Parametrised, area-folded double SHA-256 mining core. It computes SHA256(SHA256(header)) for an 80-byte block header, given the first-block midstate. A configurable number of rounds is evaluated per cycle (UNROLL), so the round logic is reused across all 64 rounds of both hashes instead of being instantiated once per round. It also sweeps a run of nonces per accepted job, stepping by NUMPROCESSORS, and is intended to tile many small cores where a full 128-stage unrolled pipeline does not fit.

## Interface
- UNROLL, 1: SHA rounds evaluated per clock. Legal values 1, 2, 4, 8; 64 % UNROLL == 0.
- PROCESSORINDEX, 0: nonce offset of this core within the array.
- NUMPROCESSORS, 1: nonce stride between successive hashes of one job.
- COUNTW, 8: width of the nonce-count field.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  job offered.
- in_ready  out  1  core idle and able to accept a job.
- in_midstate  in  256  HashState after the first 64 header bytes, words a..h.
- in_tail  in  96  header words 16..18 (merkle tail, time, bits), already in W byte order.
- in_nonce  in  32  numeric base nonce.
- in_count  in  COUNTW  number of nonces to hash.
- out_valid  out  1  result held.
- out_ready  in  1  result consumed.
- out_hash  out  256  double hash, HashState words H0..H7.
- out_nonce  out  32  numeric nonce that produced out_hash.
- job_done  out  1  one-cycle pulse when a job's sweep completes.

## Operation
- FSM states: IDLE, R1, PAD, R2, FIN, OUT.
- in_ready = (state==IDLE) && !rst.
- **IDLE**
  - On in_valid&&in_ready: latch midstate, tail, count.
  - cur_nonce = in_nonce + PROCESSORINDEX (mod 2^32).
  - If count==0: pulse job_done next cycle and stay IDLE; no output.
  - Otherwise go to R1.
- **R1**
  - Working state = midstate.
  - 16-word W window = {tail[0..2], bswap32(cur_nonce), 0x80000000, 10 × 0, 0x00000280}.
  - Each cycle applies UNROLL rounds with K[r..r+UNROLL-1]. W expands in the window: the new word is σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16].
  - Round counter r (6 bits) advances by UNROLL and wraps to 0 after 64 rounds; then go to PAD.
- **PAD** (1 cycle)
  - h1 = state + midstate, wordwise mod 2^32.
  - W window = {h1[0..7], 0x80000000, 6 × 0, 0x00000100}.
  - State = SHA-256 IV. Go to R2.
- **R2**: as R1, 64/UNROLL cycles, then FIN.
- **FIN** (1 cycle)
  - Register out_hash = state + IV and out_nonce = cur_nonce.
  - Decrement remaining count.
  - Go to OUT.
- **OUT**
  - out_valid high; out_hash and out_nonce stable until out_valid&&out_ready.
  - On handshake:
    - If remaining > 0: cur_nonce += NUMPROCESSORS (mod 2^32), go to R1 (midstate and tail reused).
    - Otherwise: pulse job_done, go to IDLE.
- All adds mod 2^32. Nonce wraps from 0xFFFFFFFF to 0x00000000 without error.
- Inputs are ignored outside IDLE.

## Timing
- Reset values:
  - state = IDLE
  - out_valid = 0, job_done = 0
  - out_hash = 0, out_nonce = 0
  - in_ready = 0 while rst is high, 1 the first cycle after release.
- Reset mid-job: abort immediately; no result or job_done is emitted.
- Latency L = 2·(64/UNROLL)+2 cycles from the accept edge to out_valid high. UNROLL=1 gives 130; UNROLL=4 gives 34.
- With out_ready tied high, successive results of one job are L+1 cycles apart.
- job_done is asserted the cycle after the final OUT handshake, or after the FIN skip when filtering is enabled.
- The earliest new accept is the cycle after job_done.
- out_ready asserted before out_valid has no effect.

## Configuration
- SHA_FOLDED_CORE_SHARE_FILTER_EN
  - Defined: in FIN, a result whose H7 != 0x00000000 is discarded. OUT is skipped and the core goes directly to the next nonce (R1) or to IDLE with job_done. Only share candidates reach out_valid.
  - Undefined: every hash is emitted.

## Test plan
- Genesis vector:
  - Stimulus: midstate from the bench's software model of the genesis header; tail = {0x4b1e5e4a, 0x29ab5f49, 0xffff001d}; in_nonce = 0x7c2bac1d; count = 1; UNROLL = 1.
  - Response: out_valid exactly 130 cycles after accept; out_hash H0 = 0x6fe28c0a, H7 = 0x00000000; out_nonce = 0x7c2bac1d; job_done follows the handshake.
- Sweep with stride:
  - Stimulus: PROCESSORINDEX = 2, NUMPROCESSORS = 4, in_nonce = 0x7c2bac13, count = 4.
  - Response: out_nonce sequence 0x7c2bac15, 0x7c2bac19, 0x7c2bac1d, 0x7c2bac21. The third result matches the genesis hash. Exactly one job_done.
- Backpressure: out_ready low for 50 cycles after out_valid -> out_hash and out_nonce held constant; no nonce advance; next result arrives L+1 cycles after the handshake.
- Edge cases:
  - in_count = 0 -> no out_valid; job_done pulses one cycle after accept.
  - in_nonce = 0xFFFFFFFF, count = 2 -> out_nonce 0xFFFFFFFF, then 0x00000000.
- Reset: assert rst in the middle of R2 -> out_valid and job_done stay 0; in_ready returns 1 the cycle after release; a new genesis job then completes correctly.
- With SHA_FOLDED_CORE_SHARE_FILTER_EN and UNROLL = 4, sweep count = 3 around the genesis nonce -> only the genesis result appears, 34 cycles after its R1 entry; one job_done.

Source files
------------

// File: rtl/sha_folded_double_core_if.sv
// Job/result bus of the folded double SHA-256 core.
// master: the side that offers jobs and consumes results; slave: the core.
interface sha_folded_double_core_if #(
    parameter int unsigned COUNTW = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [255:0]      in_midstate;
    logic [95:0]       in_tail;
    logic [31:0]       in_nonce;
    logic [COUNTW-1:0] in_count;
    logic              out_valid;
    logic              out_ready;
    logic [255:0]      out_hash;
    logic [31:0]       out_nonce;
    logic              job_done;

    modport master (
        output in_valid, in_midstate, in_tail, in_nonce, in_count, out_ready,
        input  in_ready, out_valid, out_hash, out_nonce, job_done
    );

    modport slave (
        input  in_valid, in_midstate, in_tail, in_nonce, in_count, out_ready,
        output in_ready, out_valid, out_hash, out_nonce, job_done
    );
endinterface

// File: rtl/sha_folded_double_core.sv
// Area-folded double SHA-256 mining core: SHA256(SHA256(header)) from the
// first-block midstate, UNROLL rounds per clock, sweeping in_count nonces
// per job with stride NUMPROCESSORS.
// Optional macro SHA_FOLDED_CORE_SHARE_FILTER_EN: drop every result whose
// H7 word is nonzero instead of presenting it on the result bus.
// Word packing: 256-bit states carry word a / H0 in bits [255:224];
// the 512-bit W window carries W[t] in bits [511:480].
module sha_folded_double_core #(
    parameter int unsigned UNROLL         = 1,
    parameter int unsigned PROCESSORINDEX = 0,
    parameter int unsigned NUMPROCESSORS  = 1,
    parameter int unsigned COUNTW         = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    sha_folded_double_core_if.slave bus
);

    typedef enum logic [2:0] {S_IDLE, S_R1, S_PAD, S_R2, S_FIN, S_OUT} state_t;

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] bswap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // One compression round on the packed a..h state.
    function automatic logic [255:0] sha_round(input logic [255:0] s, input logic [31:0] k,
                                               input logic [31:0] w);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = s;
        t1 = h + bsig1(e) + ((e & f) ^ (~e & g)) + k + w;
        t2 = bsig0(a) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    // Slide the 16-word schedule window by one, appending W[t+16].
    function automatic logic [511:0] win_shift(input logic [511:0] win);
        logic [31:0] nw;
        nw = ssig1(win[63:32]) + win[223:192] + ssig0(win[479:448]) + win[511:480];
        return {win[479:0], nw};
    endfunction

    function automatic logic [255:0] add8(input logic [255:0] x, input logic [255:0] y);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) begin
            r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
        end
        return r;
    endfunction

    // Second header block: tail words, byte-swapped nonce, padding, 640-bit length.
    function automatic logic [511:0] blk1_win(input logic [95:0] tail, input logic [31:0] nonce);
        return {tail, bswap32(nonce), 32'h80000000, 320'd0, 32'h00000280};
    endfunction

    // Single block of the outer hash: 32-byte digest, padding, 256-bit length.
    function automatic logic [511:0] pad_win(input logic [255:0] h1);
        return {h1, 32'h80000000, 192'd0, 32'h00000100};
    endfunction

    state_t            state_q, state_d;
    logic [5:0]        rnd_q, rnd_d;
    logic [COUNTW-1:0] remain_q, remain_d;
    logic [31:0]       nonce_q, nonce_d;
    logic              job_done_q, job_done_d;
    logic [255:0]      hash_q, hash_d;
    logic [31:0]       onon_q, onon_d;
    logic [255:0]      mid_q, mid_d;
    logic [95:0]       tail_q, tail_d;
    logic [255:0]      wk_q, wk_d;
    logic [511:0]      win_q, win_d;

    logic [255:0]      rnd_state;
    logic [511:0]      rnd_win;
    logic [255:0]      fin_hash;
    logic [31:0]       next_nonce;
    logic [31:0]       first_nonce;
    logic              rnd_last;
    logic              in_ready_w;

    assign in_ready_w    = (state_q == S_IDLE) && !rst;
    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = (state_q == S_OUT);
    assign bus.out_hash  = hash_q;
    assign bus.out_nonce = onon_q;
    assign bus.job_done  = job_done_q;

    // Folded round datapath: UNROLL chained rounds starting at round rnd_q.
    always_comb begin
        rnd_state = wk_q;
        rnd_win   = win_q;
        for (int u = 0; u < int'(UNROLL); u++) begin
            rnd_state = sha_round(rnd_state, K_TAB[rnd_q + 6'(u)], rnd_win[511:480]);
            rnd_win   = win_shift(rnd_win);
        end
    end

    // Sequencer next-state and datapath load selection.
    always_comb begin
        state_d     = state_q;
        rnd_d       = rnd_q;
        remain_d    = remain_q;
        nonce_d     = nonce_q;
        job_done_d  = 1'b0;
        hash_d      = hash_q;
        onon_d      = onon_q;
        mid_d       = mid_q;
        tail_d      = tail_q;
        wk_d        = wk_q;
        win_d       = win_q;
        fin_hash    = add8(wk_q, IV);
        next_nonce  = nonce_q + 32'(NUMPROCESSORS);
        first_nonce = bus.in_nonce + 32'(PROCESSORINDEX);
        rnd_last    = (rnd_q == 6'(64 - UNROLL));

        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid && in_ready_w) begin
                    mid_d    = bus.in_midstate;
                    tail_d   = bus.in_tail;
                    remain_d = bus.in_count;
                    nonce_d  = first_nonce;
                    if (bus.in_count == '0) begin
                        job_done_d = 1'b1;
                    end else begin
                        state_d = S_R1;
                        wk_d    = bus.in_midstate;
                        win_d   = blk1_win(bus.in_tail, first_nonce);
                        rnd_d   = 6'd0;
                    end
                end
            end
            S_R1: begin
                wk_d  = rnd_state;
                win_d = rnd_win;
                rnd_d = rnd_q + 6'(UNROLL);
                if (rnd_last) state_d = S_PAD;
            end
            S_PAD: begin
                wk_d    = IV;
                win_d   = pad_win(add8(wk_q, mid_q));
                rnd_d   = 6'd0;
                state_d = S_R2;
            end
            S_R2: begin
                wk_d  = rnd_state;
                win_d = rnd_win;
                rnd_d = rnd_q + 6'(UNROLL);
                if (rnd_last) state_d = S_FIN;
            end
            S_FIN: begin
                hash_d   = fin_hash;
                onon_d   = nonce_q;
                remain_d = remain_q - COUNTW'(1);
`ifdef SHA_FOLDED_CORE_SHARE_FILTER_EN
                if (fin_hash[31:0] != 32'd0) begin
                    // Not a share: skip the result bus and move straight on.
                    if (remain_d != '0) begin
                        nonce_d = next_nonce;
                        wk_d    = mid_q;
                        win_d   = blk1_win(tail_q, next_nonce);
                        rnd_d   = 6'd0;
                        state_d = S_R1;
                    end else begin
                        job_done_d = 1'b1;
                        state_d    = S_IDLE;
                    end
                end else begin
                    state_d = S_OUT;
                end
`else
                state_d = S_OUT;
`endif
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    if (remain_q != '0) begin
                        nonce_d = next_nonce;
                        wk_d    = mid_q;
                        win_d   = blk1_win(tail_q, next_nonce);
                        rnd_d   = 6'd0;
                        state_d = S_R1;
                    end else begin
                        job_done_d = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and result registers; reset aborts any job in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rnd_q      <= 6'd0;
            remain_q   <= '0;
            nonce_q    <= 32'd0;
            job_done_q <= 1'b0;
            hash_q     <= 256'd0;
            onon_q     <= 32'd0;
        end else begin
            state_q    <= state_d;
            rnd_q      <= rnd_d;
            remain_q   <= remain_d;
            nonce_q    <= nonce_d;
            job_done_q <= job_done_d;
            hash_q     <= hash_d;
            onon_q     <= onon_d;
        end
    end

    // Job data and working state; only meaningful once the sequencer loads them.
    always_ff @(posedge clk) begin
        mid_q  <= mid_d;
        tail_q <= tail_d;
        wk_q   <= wk_d;
        win_q  <= win_d;
    end

endmodule

// File: tb/tb_sha_folded_double_core.sv
// Bench for sha_folded_double_core: two cores (UNROLL=1 single core, and
// UNROLL=4 core 2 of 4), a software double SHA-256 model and result queues.
// Honors SHA_FOLDED_CORE_SHARE_FILTER_EN when building expectations.
module tb_sha_folded_double_core;

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [95:0]  TAIL    = 96'h4b1e5e4a_29ab5f49_ffff001d;
    localparam logic [31:0]  GEN_N   = 32'h7c2bac1d;
    localparam logic [511:0] GEN_BLK0 = {32'h01000000, 256'd0,
        32'h3ba3edfd, 32'h7a7b12b2, 32'h7ac72c3e, 32'h67768f61,
        32'h7fc81bc3, 32'h888a5132, 32'h3a9fb8aa};

    typedef struct {
        logic [255:0] h;
        logic [31:0]  n;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   vec_cnt = 0;
    int   err_cnt = 0;
    int   jda = 0;
    int   jdb = 0;
    exp_t qa[$];
    exp_t qb[$];
    logic [255:0] mid;

    sha_folded_double_core_if #(.COUNTW(8)) ifa ();
    sha_folded_double_core_if #(.COUNTW(8)) ifb ();

    sha_folded_double_core #(.UNROLL(1), .PROCESSORINDEX(0), .NUMPROCESSORS(1), .COUNTW(8)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    sha_folded_double_core #(.UNROLL(4), .PROCESSORINDEX(2), .NUMPROCESSORS(4), .COUNTW(8)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // Textbook SHA-256 compression with full 64-word schedule, feed-forward included.
    function automatic logic [255:0] compress(input logic [255:0] st, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] t1, t2, s0, s1;
        logic [255:0] r;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        for (int i = 0; i < 8; i++) v[i] = st[255 - 32*i -: 32];
        for (int i = 0; i < 64; i++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
                 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[i] + w[i];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
                 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = v[i] + st[255 - 32*i -: 32];
        return r;
    endfunction

    function automatic logic [255:0] dhash(input logic [255:0] ms, input logic [31:0] n);
        logic [255:0] h1;
        h1 = compress(ms, {TAIL, bswap(n), 32'h80000000, 320'd0, 32'h00000280});
        return compress(IV, {h1, 32'h80000000, 192'd0, 32'h00000100});
    endfunction

    // Result scoreboard for core A.
    always @(negedge clk) begin
        if (!rst && ifa.out_valid && ifa.out_ready) begin
            if (qa.size() == 0) begin
                chk("a_extra_result", 256'(qa.size()), 256'(1));
            end else begin
                exp_t e;
                e = qa.pop_front();
                chk("a_hash", ifa.out_hash, e.h);
                chk("a_nonce", 256'(ifa.out_nonce), 256'(e.n));
            end
        end
        if (!rst && ifa.job_done) jda++;
    end

    // Result scoreboard for core B.
    always @(negedge clk) begin
        if (!rst && ifb.out_valid && ifb.out_ready) begin
            if (qb.size() == 0) begin
                chk("b_extra_result", 256'(qb.size()), 256'(1));
            end else begin
                exp_t e;
                e = qb.pop_front();
                chk("b_hash", ifb.out_hash, e.h);
                chk("b_nonce", 256'(ifb.out_nonce), 256'(e.n));
            end
        end
        if (!rst && ifb.job_done) jdb++;
    end

    task automatic start_job(input bit b, input logic [31:0] base, input logic [7:0] cnt, output int acc);
        logic [31:0]  n;
        logic [255:0] h;
        bit keep;
        bit took;
        took = 1'b0;
        n = base + (b ? 32'd2 : 32'd0);
        for (int i = 0; i < int'(cnt); i++) begin
            h = dhash(mid, n);
            keep = 1'b1;
`ifdef SHA_FOLDED_CORE_SHARE_FILTER_EN
            keep = (h[31:0] == 32'd0);
`endif
            if (keep) begin
                if (b) qb.push_back('{h, n});
                else   qa.push_back('{h, n});
            end
            n = n + (b ? 32'd4 : 32'd1);
        end
        @(posedge clk); #1;
        if (b) begin
            ifb.in_midstate = mid; ifb.in_tail = TAIL; ifb.in_nonce = base; ifb.in_count = cnt; ifb.in_valid = 1'b1;
        end else begin
            ifa.in_midstate = mid; ifa.in_tail = TAIL; ifa.in_nonce = base; ifa.in_count = cnt; ifa.in_valid = 1'b1;
        end
        for (int i = 0; i < 20 && !took; i++) begin
            @(negedge clk);
            if (b ? ifb.in_ready : ifa.in_ready) took = 1'b1;
        end
        chk(b ? "b_accept" : "a_accept", 256'(took), 256'(1));
        acc = cyc + 1;
        @(posedge clk); #1;
        if (b) ifb.in_valid = 1'b0;
        else   ifa.in_valid = 1'b0;
    endtask

    task automatic wait_valid(input bit b, input int max, output int at);
        bit seen;
        seen = 1'b0;
        at = -1;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge clk);
            if (b ? ifb.out_valid : ifa.out_valid) begin
                seen = 1'b1;
                at = cyc;
            end
        end
        if (!seen) chk(b ? "b_valid_timeout" : "a_valid_timeout", 256'(seen), 256'(1));
    endtask

    task automatic wait_done(input bit b, input int max);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge clk);
            if (b ? ifb.job_done : ifa.job_done) seen = 1'b1;
        end
        chk(b ? "b_job_done" : "a_job_done", 256'(seen), 256'(1));
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, at, hs, j0;
        bit held, seen;
        logic [255:0] h0, gh;
        logic [31:0]  n0;

        rst = 1'b1;
        ifa.in_valid = 1'b0; ifa.in_midstate = '0; ifa.in_tail = '0; ifa.in_nonce = '0; ifa.in_count = '0; ifa.out_ready = 1'b0;
        ifb.in_valid = 1'b0; ifb.in_midstate = '0; ifb.in_tail = '0; ifb.in_nonce = '0; ifb.in_count = '0; ifb.out_ready = 1'b0;
        mid = compress(IV, GEN_BLK0);
        gh  = dhash(mid, GEN_N);
        chk("model_gen_h0", 256'(gh[255:224]), 256'(32'h6fe28c0a));
        chk("model_gen_h7", 256'(gh[31:0]), 256'(0));

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready_a", 256'(ifa.in_ready), 256'(0));
        chk("rst_in_ready_b", 256'(ifb.in_ready), 256'(0));
        chk("rst_out_valid", 256'(ifa.out_valid), 256'(0));
        chk("rst_job_done", 256'(ifa.job_done), 256'(0));
        chk("rst_out_hash", ifa.out_hash, 256'(0));
        chk("rst_out_nonce", 256'(ifa.out_nonce), 256'(0));
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rel_in_ready", 256'(ifa.in_ready), 256'(1));

        // Genesis vector, UNROLL=1
        @(posedge clk); #1 ifa.out_ready = 1'b1;
        start_job(1'b0, GEN_N, 8'd1, acc);
        wait_valid(1'b0, 200, at);
        chk("gen_latency", 256'(at - acc), 256'(130));
        chk("gen_h0", 256'(ifa.out_hash[255:224]), 256'(32'h6fe28c0a));
        chk("gen_h7", 256'(ifa.out_hash[31:0]), 256'(0));
        chk("gen_nonce", 256'(ifa.out_nonce), 256'(GEN_N));
        @(negedge clk);
        chk("gen_done_after_hs", 256'(ifa.job_done), 256'(1));
        chk("gen_valid_drop", 256'(ifa.out_valid), 256'(0));

        // Backpressure: hold the first result for 50 cycles
        @(posedge clk); #1 ifa.out_ready = 1'b0;
        start_job(1'b0, GEN_N, 8'd2, acc);
        wait_valid(1'b0, 200, at);
        h0 = ifa.out_hash;
        n0 = ifa.out_nonce;
        held = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (ifa.out_hash !== h0 || ifa.out_nonce !== n0 || ifa.out_valid !== 1'b1) held = 1'b0;
        end
        chk("bp_held", 256'(held), 256'(1));
        @(posedge clk); #1 ifa.out_ready = 1'b1;
        @(negedge clk);
        hs = cyc;
`ifndef SHA_FOLDED_CORE_SHARE_FILTER_EN
        wait_valid(1'b0, 200, at);
        chk("bp_next_gap", 256'(at - hs), 256'(131));
`endif
        wait_done(1'b0, 300);
        chk("bp_queue_empty", 256'(qa.size()), 256'(0));

        // Zero-count job: immediate job_done, no output
        start_job(1'b0, 32'h01020304, 8'd0, acc);
        @(negedge clk);
        chk("zero_done", 256'(ifa.job_done), 256'(1));
        seen = 1'b0;
        repeat (140) begin
            @(negedge clk);
            if (ifa.out_valid) seen = 1'b1;
        end
        chk("zero_no_output", 256'(seen), 256'(0));

        // Nonce wrap
        start_job(1'b0, 32'hffffffff, 8'd2, acc);
        wait_done(1'b0, 400);
        chk("wrap_queue_empty", 256'(qa.size()), 256'(0));

        // Reset in the middle of R2
        start_job(1'b0, GEN_N, 8'd1, acc);
        repeat (100) @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        qa.delete();
        @(negedge clk);
        chk("mid_rst_valid", 256'(ifa.out_valid), 256'(0));
        chk("mid_rst_ready", 256'(ifa.in_ready), 256'(0));
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_rel_ready", 256'(ifa.in_ready), 256'(1));
        seen = 1'b0;
        repeat (150) begin
            @(negedge clk);
            if (ifa.out_valid || ifa.job_done) seen = 1'b1;
        end
        chk("mid_rst_quiet", 256'(seen), 256'(0));
        start_job(1'b0, GEN_N, 8'd1, acc);
        wait_valid(1'b0, 200, at);
        chk("post_rst_latency", 256'(at - acc), 256'(130));
        wait_done(1'b0, 20);
        chk("post_rst_queue_empty", 256'(qa.size()), 256'(0));

        // Sweep with stride on core B (index 2 of 4, UNROLL=4)
        @(posedge clk); #1 ifb.out_ready = 1'b1;
        j0 = jdb;
        start_job(1'b1, 32'h7c2bac13, 8'd4, acc);
        wait_valid(1'b1, 300, at);
`ifdef SHA_FOLDED_CORE_SHARE_FILTER_EN
        chk("sweep_first_latency", 256'(at - acc), 256'(102));
`else
        chk("sweep_first_latency", 256'(at - acc), 256'(34));
`endif
        wait_done(1'b1, 300);
        repeat (3) @(negedge clk);
        chk("sweep_done_count", 256'(jdb - j0), 256'(1));
        chk("sweep_queue_empty", 256'(qb.size()), 256'(0));

        // Three nonces around genesis
        j0 = jdb;
        start_job(1'b1, 32'h7c2bac17, 8'd3, acc);
        wait_valid(1'b1, 300, at);
`ifdef SHA_FOLDED_CORE_SHARE_FILTER_EN
        chk("around_first_latency", 256'(at - acc), 256'(68));
        chk("around_nonce", 256'(ifb.out_nonce), 256'(GEN_N));
`else
        chk("around_first_latency", 256'(at - acc), 256'(34));
        chk("around_nonce", 256'(ifb.out_nonce), 256'(32'h7c2bac19));
`endif
        wait_done(1'b1, 300);
        repeat (3) @(negedge clk);
        chk("around_done_count", 256'(jdb - j0), 256'(1));
        chk("around_queue_empty", 256'(qb.size()), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
